// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS constants: block geometry, gearbox period and sync headers.
// Imported by the encoder, the checker and the transmit gearbox.
package pcs_pkg;

    localparam int unsigned PCS_HEAD_W  = 2;
    localparam int unsigned PCS_DATA_W  = 64;
    localparam int unsigned PCS_BLOCK_W = 66;
    localparam int unsigned GB_PERIOD   = 33;
    localparam int unsigned GB_SEQ_W    = 6;

    localparam logic [PCS_HEAD_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [PCS_HEAD_W-1:0] SYNC_CTRL = 2'b01;

    typedef logic [GB_SEQ_W-1:0] gb_seq_t;

    // Last slot of the period: no block is taken, the residual is drained.
    localparam gb_seq_t GB_FLUSH_SEQ = gb_seq_t'(GB_PERIOD - 1);

endpackage

// File: rtl/pcs_10g_tx_gearbox_if.sv
// Block-in / word-out bundle between the PCS encoder and the 66:64 transmit gearbox.
// The master is the upstream encoder, the slave is the gearbox.
interface pcs_10g_tx_gearbox_if;
    import pcs_pkg::*;

    logic [PCS_HEAD_W-1:0] head_i;
    logic [PCS_DATA_W-1:0] data_i;
    logic                  ready_o;
    logic [PCS_DATA_W-1:0] data_o;

    modport master (
        output head_i,
        output data_i,
        input  ready_o,
        input  data_o
    );

    modport slave (
        input  head_i,
        input  data_i,
        output ready_o,
        output data_o
    );

endinterface

// File: rtl/pcs_10g_tx_gearbox.sv
// 66:64 transmit gearbox: 32 blocks in, 33 words out per period, one stall slot.
// Wire order is LSB first; a block goes out as {data, head}.
module pcs_10g_tx_gearbox
    import pcs_pkg::*;
#(
    parameter int unsigned DATA_W = PCS_DATA_W,
    parameter int unsigned HEAD_W = PCS_HEAD_W
) (
    input logic                    clk,
    input logic                    nreset,
    pcs_10g_tx_gearbox_if.slave    gb
);

    localparam int unsigned BLK_W = DATA_W + HEAD_W;
    localparam int unsigned CAT_W = 2 * DATA_W + HEAD_W;

    gb_seq_t             seq_q, seq_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [CAT_W-1:0]    cat;
    logic [GB_SEQ_W:0]   shift;
    logic                flush;
    logic                unused_cat;

    assign flush      = (seq_q == GB_FLUSH_SEQ);
    assign gb.ready_o = !flush;
    assign gb.data_o  = out_q;

    always_comb begin
        shift = {seq_q, 1'b0};
        // The new block lands just above the 2*seq valid residual bits, overwriting
        // any stale residual bits above that point.
        cat = {{(CAT_W - DATA_W){1'b0}}, res_q};
        cat[shift +: BLK_W] = {gb.data_i, gb.head_i};

        if (flush) begin
            out_d = res_q;
            res_d = '0;
            seq_d = '0;
        end else begin
            out_d = cat[DATA_W-1:0];
            res_d = cat[2*DATA_W-1:DATA_W];
            seq_d = seq_q + gb_seq_t'(1);
        end
    end

    // Top two bits are only reachable when shift is 64, which is the flush slot.
    assign unused_cat = ^cat[CAT_W-1:2*DATA_W];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            seq_q <= '0;
            res_q <= '0;
            out_q <= '0;
        end else begin
            seq_q <= seq_d;
            res_q <= res_d;
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Self-checking bench for the 66:64 transmit gearbox against a bit-queue reference model.
module tb_pcs_10g_tx_gearbox;
    import pcs_pkg::*;

    logic clk;
    logic nreset;

    pcs_10g_tx_gearbox_if gb_if ();

    pcs_10g_tx_gearbox #(
        .DATA_W (64),
        .HEAD_W (2)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .gb     (gb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model: wire bits waiting to be sent, and cycles since reset.
    bit          mq[$];
    int unsigned mcnt;
    int unsigned ready_lows;
    bit          in_bits[$];
    bit          out_bits[$];
    bit          record_bits;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        return (mcnt % GB_PERIOD) != (GB_PERIOD - 1);
    endfunction

    // Present one cycle of stimulus, check ready before the edge and data_o after it.
    task automatic cycle(input logic [1:0] h, input logic [63:0] d, input string tag);
        logic [63:0] exp;
        bit          rdy;
        gb_if.head_i = h;
        gb_if.data_i = d;
        #1;
        rdy = model_ready();
        check_eq({tag, ".ready"}, {63'd0, gb_if.ready_o}, {63'd0, rdy});
        if (!gb_if.ready_o) ready_lows++;
        @(posedge clk);
        exp = '0;
        if (!nreset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (rdy) begin
                for (int i = 0; i < 2; i++) begin
                    mq.push_back(h[i]);
                    if (record_bits) in_bits.push_back(h[i]);
                end
                for (int i = 0; i < 64; i++) begin
                    mq.push_back(d[i]);
                    if (record_bits) in_bits.push_back(d[i]);
                end
            end
            for (int i = 0; i < 64; i++) begin
                if (mq.size() > 0) exp[i] = mq.pop_front();
            end
            mcnt++;
        end
        #1;
        check_eq({tag, ".data"}, gb_if.data_o, exp);
        if (record_bits) begin
            for (int i = 0; i < 64; i++) out_bits.push_back(gb_if.data_o[i]);
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        mq.delete();
        mcnt = 0;
        check_eq("reset.data", gb_if.data_o, 64'h0);
        check_eq("reset.ready", {63'd0, gb_if.ready_o}, 64'd1);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [1:0]  hh;
        logic [63:0] dd;
        int unsigned mism;
        n_checks     = 0;
        n_fail       = 0;
        ready_lows   = 0;
        record_bits  = 1'b0;
        mcnt         = 0;
        gb_if.head_i = '0;
        gb_if.data_i = '0;
        nreset       = 1'b0;
        @(posedge clk);
        do_reset();

        // Directed first two blocks.
        cycle(SYNC_DATA, 64'hFFFF_FFFF_FFFF_FFFF, "dir0");
        check_eq("dir0.const", gb_if.data_o, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle(SYNC_CTRL, 64'h0, "dir1");
        check_eq("dir1.const", gb_if.data_o, 64'h0000_0000_0000_0007);

        // Free run 330 cycles: ready low exactly once per 33 cycles.
        do_reset();
        ready_lows = 0;
        for (int c = 0; c < 330; c++) begin
            cycle(2'($urandom()), rnd64(), "free");
        end
        check_eq("free.lows", 64'(ready_lows), 64'd10);

        // Incrementing payload: flush word and full period deserialisation.
        do_reset();
        in_bits.delete();
        out_bits.delete();
        record_bits = 1'b1;
        for (int c = 0; c < 32; c++) cycle(SYNC_DATA, 64'(c), "inc");
        cycle(SYNC_DATA, 64'h20, "inc.flush");
        record_bits = 1'b0;
        check_eq("inc.flushword", gb_if.data_o, 64'h1F);
        check_eq("inc.inbits", 64'(in_bits.size()), 64'd2112);
        check_eq("inc.outbits", 64'(out_bits.size()), 64'd2112);
        mism = 0;
        for (int i = 0; i < 2112; i++) begin
            if (i < in_bits.size() && i < out_bits.size() && in_bits[i] != out_bits[i]) mism++;
        end
        check_eq("inc.deser", 64'(mism), 64'd0);

        // Random blocks for 10 periods, upstream holding the block across the flush.
        do_reset();
        hh = 2'($urandom());
        dd = rnd64();
        for (int c = 0; c < 10 * 33; c++) begin
            cycle(hh, dd, "rnd");
            if (gb_if.ready_o || (c % 33) != 32) begin
                hh = 2'($urandom());
                dd = rnd64();
            end
            if ((c % 33) == 32) check_eq("rnd.seqwrap", 64'(dut.seq_q), 64'd0);
        end

        // Mid-period reset at seq 17.
        do_reset();
        for (int c = 0; c < 17; c++) cycle(2'($urandom()), rnd64(), "pre");
        check_eq("mid.seq", 64'(dut.seq_q), 64'd17);
        nreset = 1'b0;
        cycle(2'($urandom()), rnd64(), "midrst");
        nreset = 1'b1;
        check_eq("midrst.data", gb_if.data_o, 64'h0);
        check_eq("midrst.ready", {63'd0, gb_if.ready_o}, 64'd1);
        cycle(SYNC_CTRL, 64'h0, "post0");
        check_eq("post0.const", gb_if.data_o, 64'h1);
        ready_lows = 0;
        for (int c = 0; c < 31; c++) cycle(2'($urandom()), rnd64(), "post");
        check_eq("post.nolow", 64'(ready_lows), 64'd0);
        cycle(2'($urandom()), rnd64(), "post.flush");
        check_eq("post.flushlow", 64'(ready_lows), 64'd1);

        // Junk during flush must not disturb output; held block goes next.
        do_reset();
        for (int c = 0; c < 32; c++) cycle(2'($urandom()), rnd64(), "fl");
        hh = 2'($urandom());
        dd = rnd64();
        cycle(~hh, ~dd, "fl.junk");
        cycle(hh, dd, "fl.held");
        check_eq("fl.heldlow", gb_if.data_o, {dd[61:0], hh});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
